mcpu_ctrl_fsm: RTL and testbench
================================

# mcpu_ctrl_fsm

Multicycle control unit for the MulCPU datapath. It is a Moore-style state machine that sequences each instruction through IF/ID/EXE/MEM/WB. It drives every write-enable and mux select of the PC, instruction register, register file, ALU and data memory. The free-running intermediate registers (IR-out, A, B, ALUOut, DR) latch every CLK edge; this block guarantees that each stage's inputs are stable when the next state consumes them.

## Interface
- No parameters. Opcode and state encodings come from the shared package.
- CLK  in  1  system clock, all state updates on posedge
- Reset  in  1  asynchronous, active-high; forces state to sIF
- opcode  in  6  IR[31:26] of current instruction
- zero  in  1  ALU zero flag, sampled in sEXE_BR
- state  out  3  current state encoding (debug/display)
- PCWre  out  1  PC write enable
- IRWre  out  1  instruction register write enable
- InsMemRW  out  1  instruction memory read (1 = read)
- ExtSel  out  1  immediate extend: 1 sign, 0 zero
- ALUSrcA  out  1  1 = shamt, 0 = rs data
- ALUSrcB  out  1  1 = extended immediate, 0 = rt data
- ALUOp  out  3  ALU function code
- RegWre  out  1  register file write enable
- RegDst  out  2  write reg select: 00 = $31, 01 = rt, 10 = rd
- WrRegDSrc  out  1  0 = PC+4 (jal), 1 = DB bus
- DBDataSrc  out  1  0 = ALUOut, 1 = DR
- mRD  out  1  data memory read
- mWR  out  1  data memory write
- PCSrc  out  2  00 = PC+4, 01 = branch target, 10 = jr (rs), 11 = jump target

## Operation
- Supported opcodes: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100110, sw 110000, lw 110001, beq 110100, j 111000, jr 111001, jal 111010, halt 111111.
- States: sIF 000, sID 001, sEXE_LS 010, sMEM 011, sWB_LD 100, sEXE_BR 101, sEXE_AL 110, sWB_AL 111.
- Transitions:
  - sIF -> sID always.
  - sID -> sEXE_BR for beq.
  - sID -> sEXE_LS for lw/sw.
  - sID -> sIF for j/jr/jal and for unknown opcodes; unknown opcodes retire as NOP.
  - sID -> sID for halt; the FSM holds there until Reset.
  - sID -> sEXE_AL for all other opcodes.
  - sEXE_AL -> sWB_AL -> sIF.
  - sEXE_BR -> sIF.
  - sEXE_LS -> sMEM.
  - sMEM -> sWB_LD for lw; sMEM -> sIF for sw.
  - sWB_LD -> sIF.
- PCWre = 1 only in the last state of each instruction:
  - sID for j/jr/jal/unknown; never for halt.
  - sEXE_BR.
  - sWB_AL.
  - sMEM for sw.
  - sWB_LD.
- IRWre = 1 and InsMemRW = 1 only in sIF.
- RegWre = 1 only in sWB_AL, in sWB_LD, and in sID for jal.
  - jal: RegDst = 00, WrRegDSrc = 0.
  - I-type ALU ops: RegDst = 01.
  - R-type ops: RegDst = 10.
  - lw: RegDst = 01, DBDataSrc = 1.
- mRD = 1 in sMEM for lw only; mWR = 1 in sMEM for sw only.
- PCSrc:
  - beq: 01 when zero = 1, else 00.
  - jr: 10.
  - j/jal: 11.
  - All others: 00.
- ALUOp: add 000, sub 001, or 011, and 100, sll 010, slt 110.
  - addi, lw and sw use add.
  - beq uses sub.
  - ori uses or.
- ExtSel = 0 for ori, 1 otherwise. ALUSrcA = 1 only for sll. ALUSrcB = 1 for addi/ori/lw/sw.
- Selects (ExtSel, ALUSrcA, ALUSrcB, ALUOp, RegDst, WrRegDSrc, DBDataSrc, PCSrc) are driven from opcode in every state except sIF. In sIF they are 0.
- All enables are 0 outside the states listed above.

## Timing
- Reset asserted:
  - state = sIF immediately, without waiting for CLK.
  - In sIF, IRWre = 1 and InsMemRW = 1; all other outputs are 0.
  - Reset mid-instruction aborts it; no RegWre or mWR pulse is issued after the Reset edge.
- Instruction latencies: j/jr/jal 2 cycles, beq 3, ALU ops 4, sw 4, lw 5.
- Outputs are combinational from the registered state plus opcode; they are valid within the same cycle as the state.
- zero is sampled combinationally in sEXE_BR. This is valid because ALUOut and the flag derive from the A/B registers latched in sID.

## Structure
- Shared package mcpu_pkg holds:
  - the state encodings above;
  - opcode constants;
  - ALUOp codes;
  - RegDst and PCSrc codes.
- Natural split into two parts:
  - mcpu_ctrl_fsm keeps the state register and next-state logic.
  - Sub-module mcpu_ctrl_decode is a combinational map from (state, opcode, zero) to all control outputs.

## Test plan
- Reset pulsed mid-cycle while in sEXE_AL -> state = 000 at once; RegWre stays 0; IRWre = 1.
- add (000000) -> states 000, 001, 110, 111, 000. RegWre = 1 and PCWre = 1 only in 111; RegDst = 10; ALUOp = 000.
- lw (110001) -> states 000, 001, 010, 011, 100. mRD = 1 in 011. In 100: RegWre = 1, PCWre = 1, DBDataSrc = 1, RegDst = 01.
- beq (110100) with zero = 1, then repeated with zero = 0 -> 3 cycles each; PCSrc = 01 and 00 respectively in sEXE_BR, with PCWre = 1.
- jal (111010) -> 2 cycles. In sID: RegWre = 1, RegDst = 00, WrRegDSrc = 0, PCSrc = 11, PCWre = 1.
- halt (111111) -> state holds 001 for 20 cycles with PCWre = 0 and RegWre = 0. Reset returns it to 000. An unknown opcode (e.g. 101010) retires from sID with PCWre = 1 and PCSrc = 00.

Source files
------------

// File: rtl/mcpu_pkg.sv
`default_nettype none
// ============================================================================
// Module : mcpu_pkg
// Brief  : Shared encodings for the MulCPU multicycle control unit.
// Rev    : 1.0  initial release
// ============================================================================
package mcpu_pkg;

  typedef enum logic [2:0] {
    sIF     = 3'b000,
    sID     = 3'b001,
    sEXE_LS = 3'b010,
    sMEM    = 3'b011,
    sWB_LD  = 3'b100,
    sEXE_BR = 3'b101,
    sEXE_AL = 3'b110,
    sWB_AL  = 3'b111
  } state_t;

  localparam logic [5:0] c_OP_ADD  = 6'b000000;
  localparam logic [5:0] c_OP_SUB  = 6'b000001;
  localparam logic [5:0] c_OP_ADDI = 6'b000010;
  localparam logic [5:0] c_OP_OR   = 6'b010000;
  localparam logic [5:0] c_OP_AND  = 6'b010001;
  localparam logic [5:0] c_OP_ORI  = 6'b010010;
  localparam logic [5:0] c_OP_SLL  = 6'b011000;
  localparam logic [5:0] c_OP_SLT  = 6'b100110;
  localparam logic [5:0] c_OP_SW   = 6'b110000;
  localparam logic [5:0] c_OP_LW   = 6'b110001;
  localparam logic [5:0] c_OP_BEQ  = 6'b110100;
  localparam logic [5:0] c_OP_J    = 6'b111000;
  localparam logic [5:0] c_OP_JR   = 6'b111001;
  localparam logic [5:0] c_OP_JAL  = 6'b111010;
  localparam logic [5:0] c_OP_HALT = 6'b111111;

  localparam logic [2:0] c_ALU_ADD = 3'b000;
  localparam logic [2:0] c_ALU_SUB = 3'b001;
  localparam logic [2:0] c_ALU_SLL = 3'b010;
  localparam logic [2:0] c_ALU_OR  = 3'b011;
  localparam logic [2:0] c_ALU_AND = 3'b100;
  localparam logic [2:0] c_ALU_SLT = 3'b110;

  localparam logic [1:0] c_DST_RA = 2'b00;
  localparam logic [1:0] c_DST_RT = 2'b01;
  localparam logic [1:0] c_DST_RD = 2'b10;

  localparam logic [1:0] c_PC_SEQ = 2'b00;
  localparam logic [1:0] c_PC_BR  = 2'b01;
  localparam logic [1:0] c_PC_JR  = 2'b10;
  localparam logic [1:0] c_PC_JMP = 2'b11;

  function automatic logic is_alu_op(input logic [5:0] op);
    case (op)
      c_OP_ADD, c_OP_SUB, c_OP_ADDI, c_OP_OR,
      c_OP_AND, c_OP_ORI, c_OP_SLL, c_OP_SLT: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  function automatic logic is_jump_op(input logic [5:0] op);
    return (op == c_OP_J) || (op == c_OP_JR) || (op == c_OP_JAL);
  endfunction

  function automatic logic is_known_op(input logic [5:0] op);
    return is_alu_op(op) || is_jump_op(op) || (op == c_OP_SW) ||
           (op == c_OP_LW) || (op == c_OP_BEQ) || (op == c_OP_HALT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mcpu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module : mcpu_ctrl_decode
// Brief  : Combinational map from (state, opcode, zero) to datapath controls.
// Rev    : 1.0  initial release
// ============================================================================
module mcpu_ctrl_decode
  import mcpu_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  opcode,
  input  logic        zero,
  output logic        PCWre,
  output logic        IRWre,
  output logic        InsMemRW,
  output logic        ExtSel,
  output logic        ALUSrcA,
  output logic        ALUSrcB,
  output logic [2:0]  ALUOp,
  output logic        RegWre,
  output logic [1:0]  RegDst,
  output logic        WrRegDSrc,
  output logic        DBDataSrc,
  output logic        mRD,
  output logic        mWR,
  output logic [1:0]  PCSrc
);

  logic w_lw;
  logic w_sw;
  logic w_jal;

  assign w_lw  = (opcode == c_OP_LW);
  assign w_sw  = (opcode == c_OP_SW);
  assign w_jal = (opcode == c_OP_JAL);

  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    ExtSel    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = c_ALU_ADD;
    RegWre    = 1'b0;
    RegDst    = c_DST_RA;
    WrRegDSrc = 1'b0;
    DBDataSrc = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    PCSrc     = c_PC_SEQ;

    // Enables: asserted only in the state that retires (or writes for) the instruction
    case (state)
      sIF: begin
        IRWre    = 1'b1;
        InsMemRW = 1'b1;
      end
      sID: begin
        PCWre  = is_jump_op(opcode) || !is_known_op(opcode);
        RegWre = w_jal;
      end
      sEXE_BR: PCWre = 1'b1;
      sWB_AL: begin
        PCWre  = 1'b1;
        RegWre = 1'b1;
      end
      sMEM: begin
        PCWre = w_sw;
        mRD   = w_lw;
        mWR   = w_sw;
      end
      sWB_LD: begin
        PCWre  = 1'b1;
        RegWre = 1'b1;
      end
      default: ;
    endcase

    if (state != sIF) begin
      ExtSel    = (opcode != c_OP_ORI);
      ALUSrcA   = (opcode == c_OP_SLL);
      ALUSrcB   = (opcode == c_OP_ADDI) || (opcode == c_OP_ORI) || w_lw || w_sw;
      WrRegDSrc = !w_jal;
      DBDataSrc = w_lw;

      case (opcode)
        c_OP_SUB, c_OP_BEQ: ALUOp = c_ALU_SUB;
        c_OP_OR, c_OP_ORI:  ALUOp = c_ALU_OR;
        c_OP_AND:           ALUOp = c_ALU_AND;
        c_OP_SLL:           ALUOp = c_ALU_SLL;
        c_OP_SLT:           ALUOp = c_ALU_SLT;
        default:            ALUOp = c_ALU_ADD;
      endcase

      case (opcode)
        c_OP_ADD, c_OP_SUB, c_OP_OR, c_OP_AND,
        c_OP_SLL, c_OP_SLT:           RegDst = c_DST_RD;
        c_OP_ADDI, c_OP_ORI, c_OP_LW: RegDst = c_DST_RT;
        default:                      RegDst = c_DST_RA;
      endcase

      // zero is valid here because A/B were latched in sID
      case (opcode)
        c_OP_BEQ:          PCSrc = zero ? c_PC_BR : c_PC_SEQ;
        c_OP_JR:           PCSrc = c_PC_JR;
        c_OP_J, c_OP_JAL:  PCSrc = c_PC_JMP;
        default:           PCSrc = c_PC_SEQ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mcpu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module : mcpu_ctrl_fsm
// Brief  : Multicycle IF/ID/EXE/MEM/WB sequencer for the MulCPU datapath.
// Rev    : 1.0  initial release
// ============================================================================
module mcpu_ctrl_fsm
  import mcpu_pkg::*;
(
  input  logic        CLK,
  input  logic        Reset,
  input  logic [5:0]  opcode,
  input  logic        zero,
  output logic [2:0]  state,
  output logic        PCWre,
  output logic        IRWre,
  output logic        InsMemRW,
  output logic        ExtSel,
  output logic        ALUSrcA,
  output logic        ALUSrcB,
  output logic [2:0]  ALUOp,
  output logic        RegWre,
  output logic [1:0]  RegDst,
  output logic        WrRegDSrc,
  output logic        DBDataSrc,
  output logic        mRD,
  output logic        mWR,
  output logic [1:0]  PCSrc
);

  state_t r_state;
  state_t w_next;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) r_state <= sIF;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = sIF;
    case (r_state)
      sIF: w_next = sID;
      sID: begin
        // halt parks in sID; unknown opcodes retire here as a NOP
        if (opcode == c_OP_HALT)                          w_next = sID;
        else if (opcode == c_OP_BEQ)                      w_next = sEXE_BR;
        else if (opcode == c_OP_LW || opcode == c_OP_SW)  w_next = sEXE_LS;
        else if (is_alu_op(opcode))                       w_next = sEXE_AL;
        else                                              w_next = sIF;
      end
      sEXE_AL: w_next = sWB_AL;
      sWB_AL:  w_next = sIF;
      sEXE_BR: w_next = sIF;
      sEXE_LS: w_next = sMEM;
      sMEM:    w_next = (opcode == c_OP_LW) ? sWB_LD : sIF;
      sWB_LD:  w_next = sIF;
      default: w_next = sIF;
    endcase
  end

  assign state = r_state;

  mcpu_ctrl_decode u_decode (
    .state     (r_state),
    .opcode    (opcode),
    .zero      (zero),
    .PCWre     (PCWre),
    .IRWre     (IRWre),
    .InsMemRW  (InsMemRW),
    .ExtSel    (ExtSel),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .RegWre    (RegWre),
    .RegDst    (RegDst),
    .WrRegDSrc (WrRegDSrc),
    .DBDataSrc (DBDataSrc),
    .mRD       (mRD),
    .mWR       (mWR),
    .PCSrc     (PCSrc)
  );

endmodule
`default_nettype wire

// File: tb/tb_mcpu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module : tb_mcpu_ctrl_fsm
// Brief  : Self-checking bench: cycle-indexed instruction model plus literals.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mcpu_ctrl_fsm;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic [5:0] opcode = 6'b000000;
  logic       zero = 1'b0;
  logic [2:0] state;
  logic       PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB;
  logic [2:0] ALUOp;
  logic       RegWre;
  logic [1:0] RegDst;
  logic       WrRegDSrc, DBDataSrc, mRD, mWR;
  logic [1:0] PCSrc;

  int checks = 0;
  int failures = 0;
  int m_k = 0;
  logic m_valid = 1'b0;

  logic [2:0] st_q   [32];
  logic       pcw_q  [32];
  logic       rw_q   [32];
  logic       mrd_q  [32];
  logic       dsrc_q [32];
  logic       wsrc_q [32];
  logic [1:0] dst_q  [32];
  logic [1:0] psrc_q [32];
  logic [2:0] aop_q  [32];

  always #5 CLK = ~CLK;

  mcpu_ctrl_fsm dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero), .state(state),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ExtSel(ExtSel),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegWre(RegWre),
    .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc),
    .mRD(mRD), .mWR(mWR), .PCSrc(PCSrc)
  );

  // Instruction length in cycles; 0 means it never retires (halt)
  function automatic int lat_of(input logic [5:0] op);
    case (op)
      6'b000000, 6'b000001, 6'b000010, 6'b010000,
      6'b010001, 6'b010010, 6'b011000, 6'b100110: return 4;
      6'b110000: return 4;
      6'b110001: return 5;
      6'b110100: return 3;
      6'b111111: return 0;
      default:   return 2;
    endcase
  endfunction

  // Expected outputs for cycle k of an instruction, as {state, enables, selects}
  function automatic logic [20:0] model_out(input logic [5:0] op, input logic z, input int k);
    logic [2:0] st, aop;
    logic [1:0] dst, psrc;
    logic pcw, irw, imr, ext, asa, asb, rw, wsrc, dsrc, rd, wr, alu;
    int lat;
    lat = lat_of(op);
    alu = (lat == 4) && (op != 6'b110000);
    {st, aop, dst, psrc} = '0;
    {pcw, irw, imr, ext, asa, asb, rw, wsrc, dsrc, rd, wr} = '0;
    if (k == 0) begin
      irw = 1'b1;
      imr = 1'b1;
    end else begin
      st = 3'd1;
      if (alu && k == 2) st = 3'd6;
      if (alu && k == 3) st = 3'd7;
      if ((op == 6'b110001 || op == 6'b110000) && k >= 2) st = 3'(k);
      if (op == 6'b110100 && k == 2) st = 3'd5;
      pcw  = (lat != 0) && (k == lat - 1);
      rw   = pcw && (alu || op == 6'b110001 || op == 6'b111010);
      rd   = (op == 6'b110001) && (k == 3);
      wr   = (op == 6'b110000) && (k == 3);
      ext  = (op != 6'b010010);
      asa  = (op == 6'b011000);
      asb  = (op == 6'b000010) || (op == 6'b010010) || (op == 6'b110001) || (op == 6'b110000);
      wsrc = (op != 6'b111010);
      dsrc = (op == 6'b110001);
      case (op)
        6'b000001, 6'b110100: aop = 3'b001;
        6'b010000, 6'b010010: aop = 3'b011;
        6'b010001:            aop = 3'b100;
        6'b011000:            aop = 3'b010;
        6'b100110:            aop = 3'b110;
        default:              aop = 3'b000;
      endcase
      if (alu) dst = (op == 6'b000010 || op == 6'b010010) ? 2'b01 : 2'b10;
      if (op == 6'b110001) dst = 2'b01;
      if (op == 6'b110100) psrc = z ? 2'b01 : 2'b00;
      if (op == 6'b111001) psrc = 2'b10;
      if (op == 6'b111000 || op == 6'b111010) psrc = 2'b11;
    end
    return {st, pcw, irw, imr, ext, asa, asb, aop, rw, dst, wsrc, dsrc, rd, wr, psrc};
  endfunction

  always @(posedge CLK or posedge Reset) begin
    if (Reset)                          m_k <= 0;
    else if (lat_of(opcode) == 0)       m_k <= 1;
    else if (m_k + 1 >= lat_of(opcode)) m_k <= 0;
    else                                m_k <= m_k + 1;
  end

  always @(negedge CLK) begin
    logic [20:0] exp_v, obs_v;
    if (m_valid) begin
      exp_v = model_out(opcode, zero, m_k);
      obs_v = {state, PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB, ALUOp,
               RegWre, RegDst, WrRegDSrc, DBDataSrc, mRD, mWR, PCSrc};
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL model op=%b k=%0d got=%06h exp=%06h t=%0t", opcode, m_k, obs_v, exp_v, $time);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, expv);
    end
  endtask

  // Runs one instruction for n cycles, starting just after an edge into sIF
  task automatic run_instr(input logic [5:0] op, input logic z, input int n);
    opcode = op;
    zero   = z;
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      st_q[k] = state;  pcw_q[k] = PCWre; rw_q[k] = RegWre; mrd_q[k] = mRD;
      dsrc_q[k] = DBDataSrc; wsrc_q[k] = WrRegDSrc; dst_q[k] = RegDst;
      psrc_q[k] = PCSrc; aop_q[k] = ALUOp;
      @(posedge CLK);
    end
    #1;
  endtask

  function automatic logic [31:0] seq_of(input int n);
    logic [31:0] s = '0;
    for (int k = 0; k < n; k++) s = (s << 3) | 32'(st_q[k]);
    return s;
  endfunction

  function automatic logic [31:0] bits_of(input int n, input logic sel_rw);
    logic [31:0] s = '0;
    for (int k = 0; k < n; k++) s = (s << 1) | 32'(sel_rw ? rw_q[k] : pcw_q[k]);
    return s;
  endfunction

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_irwre", 32'(IRWre), 32'd1);
    chk("rst_insmem", 32'(InsMemRW), 32'd1);
    chk("rst_pcwre", 32'(PCWre), 32'd0);
    chk("rst_regwre", 32'(RegWre), 32'd0);
    Reset = 1'b0;
    m_valid = 1'b1;

    run_instr(6'b000000, 1'b0, 4);
    chk("add_seq", seq_of(4), 32'b000_001_110_111);
    chk("add_pcw", bits_of(4, 1'b0), 32'b0001);
    chk("add_rw", bits_of(4, 1'b1), 32'b0001);
    chk("add_dst", 32'(dst_q[3]), 32'b10);
    chk("add_aop", 32'(aop_q[2]), 32'b000);

    run_instr(6'b110001, 1'b0, 5);
    chk("lw_seq", seq_of(5), 32'b000_001_010_011_100);
    chk("lw_mrd", 32'(mrd_q[3]), 32'd1);
    chk("lw_wb", 32'({rw_q[4], pcw_q[4], dsrc_q[4], dst_q[4]}), 32'b11101);

    run_instr(6'b110100, 1'b1, 3);
    chk("beq1_seq", seq_of(3), 32'b000_001_101);
    chk("beq1_pc", 32'({pcw_q[2], psrc_q[2]}), 32'b101);
    run_instr(6'b110100, 1'b0, 3);
    chk("beq0_pc", 32'({pcw_q[2], psrc_q[2]}), 32'b100);

    run_instr(6'b111010, 1'b0, 2);
    chk("jal_seq", seq_of(2), 32'b000_001);
    chk("jal_id", 32'({rw_q[1], dst_q[1], wsrc_q[1], psrc_q[1], pcw_q[1]}), 32'b1_00_0_11_1);

    run_instr(6'b000001, 1'b0, 4);
    run_instr(6'b000010, 1'b0, 4);
    run_instr(6'b010000, 1'b0, 4);
    run_instr(6'b010001, 1'b0, 4);
    run_instr(6'b010010, 1'b0, 4);
    run_instr(6'b011000, 1'b0, 4);
    run_instr(6'b100110, 1'b0, 4);
    run_instr(6'b110000, 1'b0, 4);
    run_instr(6'b111000, 1'b0, 2);
    run_instr(6'b111001, 1'b0, 2);

    // Abort an add in sEXE_AL with a mid-cycle reset
    opcode = 6'b000000;
    repeat (2) @(posedge CLK);
    #1;
    chk("abort_pre", 32'(state), 32'd6);
    #1 Reset = 1'b1;
    #1;
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_rw", 32'(RegWre), 32'd0);
    chk("abort_irw", 32'(IRWre), 32'd1);
    @(posedge CLK);
    #1 Reset = 1'b0;

    run_instr(6'b111111, 1'b0, 21);
    chk("halt_state", 32'(st_q[20]), 32'd1);
    chk("halt_pcw", bits_of(21, 1'b0), 32'd0);
    chk("halt_rw", bits_of(21, 1'b1), 32'd0);
    Reset = 1'b1;
    #2;
    chk("halt_rst", 32'(state), 32'd0);
    @(posedge CLK);
    #1 Reset = 1'b0;

    run_instr(6'b101010, 1'b0, 2);
    chk("unk_seq", seq_of(2), 32'b000_001);
    chk("unk_pc", 32'({pcw_q[1], psrc_q[1]}), 32'b100);

    run_instr(6'b000000, 1'b0, 4);
    m_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
